// File: rtl/pdm_cic_decimator.sv
// pdm_cic_decimator: N-stage CIC decimator (differential delay 1) that turns a
// strobed 1-bit PDM stream into signed PCM samples at 1/DECIM_R of the strobe
// rate, presented through a single-entry valid/ready output register.
// Optional DC-removal high-pass after output scaling: define CIC_DC_BLOCK_EN.
module pdm_cic_decimator #(
    parameter int N_STAGES = 3,
    parameter int DECIM_R  = 16,
    parameter int OUT_W    = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    pdm_valid_in,
    input  logic                    pdm_bit_in,
    input  logic                    sample_ready_in,
    output logic                    sample_valid_out,
    output logic signed [OUT_W-1:0] sample_out,
    output logic                    overrun_out
);

    localparam int LOG2_R = $clog2(DECIM_R);
    localparam int ACC_W  = 2 + N_STAGES * LOG2_R;

    typedef logic signed [ACC_W-1:0] acc_t;

    // integrator section
    acc_t                    r_integ      [N_STAGES];
    acc_t                    w_integ_next [N_STAGES];
    acc_t                    w_x;
    acc_t                    w_chain;
    logic [LOG2_R-1:0]       r_dec_cnt;
    logic                    w_frame_end;

    // comb section
    acc_t                    r_comb_in;
    logic                    r_comb_in_vld;
    acc_t                    w_stage_in   [N_STAGES];
    logic [N_STAGES-1:0]     w_stage_vld;
    acc_t                    r_comb       [N_STAGES];
    acc_t                    r_comb_prev  [N_STAGES];
    logic [N_STAGES-1:0]     r_comb_vld;

    // scaling and output
    logic signed [OUT_W-1:0] w_scaled;
    logic signed [OUT_W-1:0] r_scaled;
    logic                    r_scaled_vld;
    logic signed [OUT_W-1:0] w_new_sample;
    logic                    w_new_vld;
    logic signed [OUT_W-1:0] r_sample;
    logic                    r_valid;
    logic                    r_overrun;

    // Map the PDM bit to +/-1 and ripple it through the integrator cascade;
    // the captured frame value already includes the current strobe.
    always_comb begin
        w_x     = pdm_bit_in ? acc_t'(1) : '1;
        w_chain = w_x;
        for (int unsigned k = 0; k < N_STAGES; k++) begin
            w_chain         = r_integ[k] + w_chain;
            w_integ_next[k] = w_chain;
        end
    end

    // Last strobe of a frame: the counter is about to wrap to zero.
    always_comb begin
        w_frame_end = pdm_valid_in && (r_dec_cnt == LOG2_R'(DECIM_R - 1));
    end

    // Integrators and decimation counter advance only on strobes (wrapping).
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_dec_cnt <= '0;
            for (int unsigned k = 0; k < N_STAGES; k++) begin
                r_integ[k] <= '0;
            end
        end else if (pdm_valid_in) begin
            r_dec_cnt <= r_dec_cnt + LOG2_R'(1);
            for (int unsigned k = 0; k < N_STAGES; k++) begin
                r_integ[k] <= w_integ_next[k];
            end
        end
    end

    // Route each comb stage's input from the previous stage's register.
    always_comb begin
        w_stage_in[0]  = r_comb_in;
        w_stage_vld[0] = r_comb_in_vld;
        for (int unsigned k = 1; k < N_STAGES; k++) begin
            w_stage_in[k]  = r_comb[k-1];
            w_stage_vld[k] = r_comb_vld[k-1];
        end
    end

    // Frame capture plus pipelined comb stages; each x_prev moves only with
    // valid input so the combs run strictly at the decimated rate.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_comb_in     <= '0;
            r_comb_in_vld <= 1'b0;
            r_comb_vld    <= '0;
            for (int unsigned k = 0; k < N_STAGES; k++) begin
                r_comb[k]      <= '0;
                r_comb_prev[k] <= '0;
            end
        end else begin
            r_comb_in_vld <= w_frame_end;
            if (w_frame_end) begin
                r_comb_in <= w_integ_next[N_STAGES-1];
            end
            r_comb_vld <= w_stage_vld;
            for (int unsigned k = 0; k < N_STAGES; k++) begin
                if (w_stage_vld[k]) begin
                    r_comb[k]      <= w_stage_in[k] - r_comb_prev[k];
                    r_comb_prev[k] <= w_stage_in[k];
                end
            end
        end
    end

    // Fit the ACC_W comb result into OUT_W bits.
    if (ACC_W <= OUT_W) begin : g_scale_up
        always_comb begin
            w_scaled = OUT_W'(r_comb[N_STAGES-1]) <<< (OUT_W - ACC_W);
        end
    end else begin : g_scale_down
        always_comb begin
            w_scaled = OUT_W'(r_comb[N_STAGES-1] >>> (ACC_W - OUT_W));
        end
    end

    // Register the scaled comb output.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_scaled     <= '0;
            r_scaled_vld <= 1'b0;
        end else begin
            r_scaled_vld <= r_comb_vld[N_STAGES-1];
            if (r_comb_vld[N_STAGES-1]) begin
                r_scaled <= w_scaled;
            end
        end
    end

`ifdef CIC_DC_BLOCK_EN
    localparam logic signed [OUT_W+1:0] DC_MAX = (OUT_W+2)'(2**(OUT_W-1) - 1);
    localparam logic signed [OUT_W+1:0] DC_MIN = (OUT_W+2)'(-(2**(OUT_W-1)));

    logic signed [OUT_W+1:0] w_dc_sum;
    logic signed [OUT_W-1:0] w_dc_sat;
    logic signed [OUT_W-1:0] r_dc_x_prev;
    logic signed [OUT_W-1:0] r_dc_y;
    logic                    r_dc_vld;

    // y = x - x_prev + y_prev - (y_prev >>> 8), saturated back to OUT_W.
    always_comb begin
        w_dc_sum = (OUT_W+2)'(r_scaled) - (OUT_W+2)'(r_dc_x_prev)
                 + (OUT_W+2)'(r_dc_y) - (OUT_W+2)'(r_dc_y >>> 8);
        if (w_dc_sum > DC_MAX) begin
            w_dc_sat = OUT_W'(DC_MAX);
        end else if (w_dc_sum < DC_MIN) begin
            w_dc_sat = OUT_W'(DC_MIN);
        end else begin
            w_dc_sat = OUT_W'(w_dc_sum);
        end
    end

    // DC-block state advances once per scaled sample.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_dc_x_prev <= '0;
            r_dc_y      <= '0;
            r_dc_vld    <= 1'b0;
        end else begin
            r_dc_vld <= r_scaled_vld;
            if (r_scaled_vld) begin
                r_dc_x_prev <= r_scaled;
                r_dc_y      <= w_dc_sat;
            end
        end
    end

    assign w_new_sample = r_dc_y;
    assign w_new_vld    = r_dc_vld;
`else
    assign w_new_sample = r_scaled;
    assign w_new_vld    = r_scaled_vld;
`endif

    // Single-entry output register: a new sample always wins; overwriting an
    // unconsumed sample latches the sticky overrun flag.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_sample  <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_new_vld) begin
            r_sample <= w_new_sample;
            r_valid  <= 1'b1;
            if (r_valid && !sample_ready_in) begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && sample_ready_in) begin
            r_valid <= 1'b0;
        end
    end

    assign sample_valid_out = r_valid;
    assign sample_out       = r_sample;
    assign overrun_out      = r_overrun;

endmodule
